// File: rtl/wb_queue_stage.sv
// wb_queue_stage: DEPTH-entry in-order write-back queue with per-byte RF writes and decode bypass lookup.
// Define WB_TRACE_EN to add the debug_wb_* retire trace outputs.
module wb_queue_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 2,
    localparam int BE_W  = DATA_W / 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic              ms_we,
    input  logic [BE_W-1:0]   ms_be,
    input  logic [ADDR_W-1:0] ms_dest,
    input  logic [DATA_W-1:0] ms_result,
    input  logic [PC_W-1:0]   ms_pc,
    input  logic              rf_ready,
    output logic [BE_W-1:0]   rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] ds_rd_addr,
    output logic              ws_hit,
    output logic              ws_hit_full,
    output logic [DATA_W-1:0] ws_hit_data,
`ifdef WB_TRACE_EN
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [BE_W-1:0]   debug_wb_rf_wen,
    output logic [ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata,
`endif
    output logic [CNT_W-1:0]  ws_count
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DEPTH-1:0]  e_valid, e_we;
    logic [BE_W-1:0]   e_be   [DEPTH];
    logic [ADDR_W-1:0] e_dest [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];
`ifdef WB_TRACE_EN
    logic [PC_W-1:0]   e_pc   [DEPTH];
`endif
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, idx;
    logic [CNT_W-1:0]  count;
    logic              head_writing, push, pop;

    assign head_writing = e_valid[rd_ptr] && e_we[rd_ptr] && |e_be[rd_ptr] && e_dest[rd_ptr] != '0;
    // non-writing heads drain even while the RF port is busy
    assign pop        = e_valid[rd_ptr] && (rf_ready || !head_writing);
    assign ws_allowin = count < CNT_W'(DEPTH) || pop;
    assign push       = ms_to_ws_valid && ws_allowin;
    assign rf_we      = head_writing && rf_ready ? e_be[rd_ptr] : '0;
    assign rf_waddr   = e_valid[rd_ptr] ? e_dest[rd_ptr] : '0;
    assign rf_wdata   = e_valid[rd_ptr] ? e_data[rd_ptr] : '0;
    assign ws_count   = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            e_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_W'(1);
                e_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_W'(1);
                e_valid[wr_ptr] <= 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            e_we[wr_ptr]   <= ms_we;
            e_be[wr_ptr]   <= ms_be;
            e_dest[wr_ptr] <= ms_dest;
            e_data[wr_ptr] <= ms_result;
`ifdef WB_TRACE_EN
            e_pc[wr_ptr]   <= ms_pc;
`endif
        end
    end

    // walk oldest to youngest so the last match wins
    always_comb begin
        ws_hit      = 1'b0;
        ws_hit_full = 1'b0;
        ws_hit_data = '0;
        idx         = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (e_valid[idx] && e_we[idx] && |e_be[idx] && ds_rd_addr != '0 && e_dest[idx] == ds_rd_addr) begin
                ws_hit      = 1'b1;
                ws_hit_full = &e_be[idx];
                ws_hit_data = e_data[idx];
            end
        end
    end

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = pop ? e_pc[rd_ptr] : '0;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = pop ? rf_waddr : '0;
    assign debug_wb_rf_wdata = pop ? rf_wdata : '0;
`else
    logic unused_pc;
    assign unused_pc = ^ms_pc;
`endif
endmodule

// File: tb/tb_wb_queue_stage.sv
// tb_wb_queue_stage: directed scenarios plus randomized run against a queue-based reference model.
module tb_wb_queue_stage;
    localparam int DEPTH = 2;
    logic        clk = 0, reset = 1, ms_to_ws_valid = 0, ms_we = 0, rf_ready = 0;
    logic [3:0]  ms_be = 0;
    logic [4:0]  ms_dest = 0, ds_rd_addr = 0;
    logic [31:0] ms_result = 0, ms_pc = 0;
    logic        ws_allowin, ws_hit, ws_hit_full;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, ws_hit_data;
    logic [1:0]  ws_count;
    int checks = 0, failures = 0;

    wb_queue_stage #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_we(ms_we), .ms_be(ms_be), .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ds_rd_addr(ds_rd_addr), .ws_hit(ws_hit), .ws_hit_full(ws_hit_full),
        .ws_hit_data(ws_hit_data), .ws_count(ws_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    logic        e_pop, e_allow, e_hit, e_full;
    logic [3:0]  e_rfwe;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_hdata;

    function automatic bit writes(ent_t e);
        return e.we && e.be != 0 && e.dest != 0;
    endfunction

    function automatic void model_eval();
        e_pop = 0; e_rfwe = 0; e_waddr = 0; e_wdata = 0;
        if (q.size() > 0) begin
            e_pop   = rf_ready || !writes(q[0]);
            e_rfwe  = (writes(q[0]) && rf_ready) ? q[0].be : 4'h0;
            e_waddr = q[0].dest;
            e_wdata = q[0].data;
        end
        e_allow = q.size() < DEPTH || e_pop;
        e_hit = 0; e_full = 0; e_hdata = 0;
        foreach (q[i])
            if (writes(q[i]) && ds_rd_addr != 0 && q[i].dest == ds_rd_addr) begin
                e_hit = 1; e_full = q[i].be == 4'hF; e_hdata = q[i].data;
            end
    endfunction

    function automatic void model_clock();
        ent_t e;
        model_eval();
        if (reset) q.delete();
        else begin
            if (e_pop) void'(q.pop_front());
            if (ms_to_ws_valid && e_allow) begin
                e.we = ms_we; e.be = ms_be; e.dest = ms_dest; e.data = ms_result;
                q.push_back(e);
            end
        end
    endfunction

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit we, input bit [3:0] be, input bit [4:0] dest, input bit [31:0] data);
        ms_to_ws_valid = v; ms_we = we; ms_be = be; ms_dest = dest; ms_result = data; ms_pc = $urandom;
    endtask

    task automatic test_reset();
        reset = 1; rf_ready = 0; ds_rd_addr = 5; drive(0, 0, 0, 0, 0);
        tick(); tick();
        reset = 0;
        @(negedge clk);
        checks++; if (ws_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ws_count); end
        checks++; if (rf_we !== 4'h0) begin failures++; $display("FAIL reset_rf_we got=%h exp=0", rf_we); end
        checks++; if (ws_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", ws_allowin); end
        checks++; if ({ws_hit, ws_hit_full} !== 2'b00) begin failures++; $display("FAIL reset_hit got=%b%b exp=00", ws_hit, ws_hit_full); end
        checks++; if (ws_hit_data !== 32'h0) begin failures++; $display("FAIL reset_hit_data got=%h exp=0", ws_hit_data); end
        tick();
    endtask

    task automatic test_single();
        rf_ready = 1; drive(1, 1, 4'hF, 8, 32'h12345678); ms_pc = 32'hBFC00000;
        @(negedge clk);
        checks++; if (ws_allowin !== 1'b1) begin failures++; $display("FAIL single_allowin got=%b exp=1", ws_allowin); end
        tick();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (rf_we !== 4'hF) begin failures++; $display("FAIL single_rf_we got=%h exp=f", rf_we); end
        checks++; if (rf_waddr !== 5'd8) begin failures++; $display("FAIL single_waddr got=%0d exp=8", rf_waddr); end
        checks++; if (rf_wdata !== 32'h12345678) begin failures++; $display("FAIL single_wdata got=%h exp=12345678", rf_wdata); end
        checks++; if (ws_count !== 2'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", ws_count); end
        tick();
        @(negedge clk);
        checks++; if (ws_count !== 2'd0 || rf_we !== 4'h0) begin failures++; $display("FAIL single_drain got=%0d/%h exp=0/0", ws_count, rf_we); end
        tick();
    endtask

    task automatic test_backpressure();
        rf_ready = 0;
        drive(1, 1, 4'hF, 1, 32'h11); tick();
        drive(1, 1, 4'hF, 2, 32'h22); tick();
        drive(1, 1, 4'hF, 3, 32'h33);
        @(negedge clk);
        checks++; if (ws_count !== 2'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", ws_count); end
        checks++; if (ws_allowin !== 1'b0 || rf_we !== 4'h0) begin failures++; $display("FAIL bp_stall got=%b/%h exp=0/0", ws_allowin, rf_we); end
        tick();
        rf_ready = 1;
        @(negedge clk);
        checks++; if (ws_allowin !== 1'b1) begin failures++; $display("FAIL bp_release_allowin got=%b exp=1", ws_allowin); end
        checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd1 || rf_wdata !== 32'h11) begin failures++; $display("FAIL bp_write1 got=%h/%0d/%h exp=f/1/11", rf_we, rf_waddr, rf_wdata); end
        tick();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) begin failures++; $display("FAIL bp_write2 got=%h/%0d/%h exp=f/2/22", rf_we, rf_waddr, rf_wdata); end
        tick();
        @(negedge clk);
        checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin failures++; $display("FAIL bp_write3 got=%h/%0d/%h exp=f/3/33", rf_we, rf_waddr, rf_wdata); end
        tick();
        @(negedge clk);
        checks++; if (ws_count !== 2'd0) begin failures++; $display("FAIL bp_drain got=%0d exp=0", ws_count); end
        tick();
    endtask

    task automatic test_nonwriting();
        rf_ready = 0;
        drive(1, 0, 4'hF, 7, 32'h77); tick();
        drive(1, 1, 4'hF, 3, 32'h33);
        @(negedge clk);
        checks++; if (rf_we !== 4'h0 || ws_allowin !== 1'b1) begin failures++; $display("FAIL nw_retire got=%h/%b exp=0/1", rf_we, ws_allowin); end
        tick();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (ws_count !== 2'd1 || rf_we !== 4'h0) begin failures++; $display("FAIL nw_wait got=%0d/%h exp=1/0", ws_count, rf_we); end
        tick();
        rf_ready = 1;
        @(negedge clk);
        checks++; if (rf_we !== 4'hF || rf_waddr !== 5'd3) begin failures++; $display("FAIL nw_write got=%h/%0d exp=f/3", rf_we, rf_waddr); end
        tick();
    endtask

    task automatic test_bypass();
        rf_ready = 0; ds_rd_addr = 5;
        drive(1, 1, 4'hF, 5, 32'hAAAA0000); tick();
        drive(1, 1, 4'h1, 5, 32'h000000BB);
        @(negedge clk);
        checks++; if (ws_hit !== 1'b1 || ws_hit_full !== 1'b1 || ws_hit_data !== 32'hAAAA0000) begin failures++; $display("FAIL byp_older got=%b/%b/%h exp=1/1/aaaa0000", ws_hit, ws_hit_full, ws_hit_data); end
        tick();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (ws_hit !== 1'b1 || ws_hit_full !== 1'b0 || ws_hit_data !== 32'h000000BB) begin failures++; $display("FAIL byp_younger got=%b/%b/%h exp=1/0/000000bb", ws_hit, ws_hit_full, ws_hit_data); end
        ds_rd_addr = 6; #1;
        checks++; if (ws_hit !== 1'b0) begin failures++; $display("FAIL byp_miss got=%b exp=0", ws_hit); end
        tick();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        checks++; if (ws_count !== 2'd2) begin failures++; $display("FAIL rm_full got=%0d exp=2", ws_count); end
        reset = 1; tick();
        reset = 0; rf_ready = 1; ds_rd_addr = 5;
        @(negedge clk);
        checks++; if (ws_count !== 2'd0 || rf_we !== 4'h0 || ws_allowin !== 1'b1 || ws_hit !== 1'b0) begin failures++; $display("FAIL rm_flush got=%0d/%h/%b/%b exp=0/0/1/0", ws_count, rf_we, ws_allowin, ws_hit); end
        tick();
        rf_ready = 0; drive(1, 1, 4'hF, 0, 32'hDEAD); tick();
        drive(0, 0, 0, 0, 0); ds_rd_addr = 0;
        @(negedge clk);
        checks++; if (ws_hit !== 1'b0 || rf_we !== 4'h0 || ws_count !== 2'd1) begin failures++; $display("FAIL rm_dest0 got=%b/%h/%0d exp=0/0/1", ws_hit, rf_we, ws_count); end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] dat[10];
        logic [31:0] got[$];
        int sent = 0, cyc = 0;
        bit acc;
        foreach (dat[i]) dat[i] = $urandom;
        while ((sent < 10 || got.size() < 10) && cyc < 200) begin
            rf_ready = (cyc % 2 == 0);
            if (sent < 10) drive(1, 1, 4'hF, 5'(sent + 1), dat[sent]);
            else drive(0, 0, 0, 0, 0);
            @(negedge clk);
            if (rf_we != 0) got.push_back(rf_wdata);
            acc = ms_to_ws_valid && ws_allowin;
            tick();
            if (acc) sent++;
            cyc++;
        end
        checks++; if (got.size() != 10) begin failures++; $display("FAIL wrap_writes got=%0d exp=10", got.size()); end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            checks++; if (got[i] !== dat[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, got[i], dat[i]); end
        end
        drive(0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom % 64 == 0);
            rf_ready = 1'($urandom);
            drive(1'($urandom), 1'($urandom), 4'($urandom), 5'($urandom % 8), $urandom);
            ds_rd_addr = 5'($urandom % 8);
            @(negedge clk);
            model_eval();
            checks++; if (ws_allowin !== e_allow) begin failures++; $display("FAIL rnd_allowin cyc=%0d got=%b exp=%b", n, ws_allowin, e_allow); end
            checks++; if (rf_we !== e_rfwe) begin failures++; $display("FAIL rnd_rf_we cyc=%0d got=%h exp=%h", n, rf_we, e_rfwe); end
            if (e_rfwe != 0) begin
                checks++; if (rf_waddr !== e_waddr || rf_wdata !== e_wdata) begin failures++; $display("FAIL rnd_wr cyc=%0d got=%0d/%h exp=%0d/%h", n, rf_waddr, rf_wdata, e_waddr, e_wdata); end
            end
            checks++; if (ws_hit !== e_hit || ws_hit_full !== e_full) begin failures++; $display("FAIL rnd_hit cyc=%0d got=%b%b exp=%b%b", n, ws_hit, ws_hit_full, e_hit, e_full); end
            if (e_hit) begin
                checks++; if (ws_hit_data !== e_hdata) begin failures++; $display("FAIL rnd_hit_data cyc=%0d got=%h exp=%h", n, ws_hit_data, e_hdata); end
            end
            checks++; if (ws_count !== 2'(q.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", n, ws_count, q.size()); end
            tick();
        end
        reset = 0; drive(0, 0, 0, 0, 0); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_nonwriting();
        test_bypass();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
